// File: rtl/ttl_sched_pkg.sv
// ttl_sched_pkg
// Shared constants and helpers for the TTL clock-edge scheduler.
//
// Build option:
//   TTL_SCHED_SYNC2_EN  defined   -> two-flop synchronisers on all TTL inputs
//                       undefined -> single sampling flop (inputs must already
//                                    be clk-synchronous)
//
// Contents:
//   SYNC_DEPTH     number of synchroniser stages on tclk/tclr_n/tpre_n
//   N_MAX          largest supported bank count
//   IDX_W          index width able to address N_MAX banks
//   onehot_to_idx  one-hot (or zero) vector to binary index
package ttl_sched_pkg;

`ifdef TTL_SCHED_SYNC2_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  localparam int N_MAX = 16;
  localparam int IDX_W = $clog2(N_MAX);

  // OR-reduction encoder: for a one-hot input the result is the index of the
  // set bit; an all-zero input yields 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_MAX-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ttl_rr_arbiter.sv
// ttl_rr_arbiter
// Purely combinational round-robin selector. Searches req starting at ptr,
// moving upward and wrapping from N-1 back to 0, and grants the first set bit.
//
// Ports:
//   req        in   N      request vector
//   ptr        in   PTR_W  bank that has highest priority this cycle
//   grant      out  N      one-hot grant, all zero when nothing requested
//   grant_idx  out  PTR_W  binary index of the granted bank (0 when !valid)
//   valid      out  1      a grant was made
module ttl_rr_arbiter
  import ttl_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             valid
);

  // One extra bit so ptr + offset (< 2N) never overflows before the wrap.
  localparam int SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(N)) begin
        sum = sum - SUM_W'(N);
      end
      cand = sum[PTR_W-1:0];
      if (!valid && req[cand]) begin
        grant[cand] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

  assign grant_idx = PTR_W'(onehot_to_idx(N_MAX'(grant)));

endmodule

// File: rtl/ttl_clk_edge_sched.sv
// ttl_clk_edge_sched
// Clock-enable scheduler for emulated 7474-class flip-flop banks. Samples N
// TTL clock nets plus their clear/preset nets in the system clock domain,
// turns every rising clock edge into one registered single-cycle enable
// strobe, and serialises those strobes round-robin so that at most one bank
// is clocked per cycle. Also delivers conditioned clear/preset levels with
// clear dominant over preset.
//
// Build option: TTL_SCHED_SYNC2_EN selects two-flop synchronisers
// (see ttl_sched_pkg); default is a single sampling flop.
//
// Ports:
//   clk      in   1  system clock
//   reset_n  in   1  asynchronous active-low reset
//   run      in   1  1 = grants allowed, 0 = grants frozen (edges still captured)
//   tclk     in   N  TTL clock nets
//   tclr_n   in   N  TTL clear nets, active-low
//   tpre_n   in   N  TTL preset nets, active-low
//   ovf_clr  in   1  pulse clearing all sticky overflow flags
//   ce       out  N  one-hot (or zero) clock-enable strobe
//   clr_n_o  out  N  registered clear per bank, active-low
//   pre_n_o  out  N  registered preset per bank, active-low, 1 while clearing
//   pending  out  N  edge captured, strobe not yet issued
//   ovf      out  N  sticky: a second edge arrived before the first was served
module ttl_clk_edge_sched
  import ttl_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         run,
  input  logic [N-1:0] tclk,
  input  logic [N-1:0] tclr_n,
  input  logic [N-1:0] tpre_n,
  input  logic         ovf_clr,
  output logic [N-1:0] ce,
  output logic [N-1:0] clr_n_o,
  output logic [N-1:0] pre_n_o,
  output logic [N-1:0] pending,
  output logic [N-1:0] ovf
);

  localparam int PTR_W = $clog2(N);

  // Synchroniser chains; index SYNC_DEPTH-1 is the conditioned output.
  logic [N-1:0] sync_tclk_reg [SYNC_DEPTH];
  logic [N-1:0] sync_tclr_reg [SYNC_DEPTH];
  logic [N-1:0] sync_tpre_reg [SYNC_DEPTH];

  logic [N-1:0] s_tclk;
  logic [N-1:0] s_tclr_n;
  logic [N-1:0] s_tpre_n;

  logic [N-1:0] prev_tclk_reg;
  logic [N-1:0] edge_det;

  logic [N-1:0] pending_reg, pending_next;
  logic [N-1:0] ovf_reg, ovf_next;
  logic [N-1:0] ce_reg;
  logic [N-1:0] clr_reg;
  logic [N-1:0] pre_reg, pre_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_valid;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Clock chain resets low and clear/preset chains reset
  // high so that the idle levels are already present after reset and no edge
  // or clear pulse is invented on the first cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) begin
        sync_tclk_reg[i] <= '0;
        sync_tclr_reg[i] <= '1;
        sync_tpre_reg[i] <= '1;
      end
    end else begin
      sync_tclk_reg[0] <= tclk;
      sync_tclr_reg[0] <= tclr_n;
      sync_tpre_reg[0] <= tpre_n;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        sync_tclk_reg[i] <= sync_tclk_reg[i-1];
        sync_tclr_reg[i] <= sync_tclr_reg[i-1];
        sync_tpre_reg[i] <= sync_tpre_reg[i-1];
      end
    end
  end

  assign s_tclk   = sync_tclk_reg[SYNC_DEPTH-1];
  assign s_tclr_n = sync_tclr_reg[SYNC_DEPTH-1];
  assign s_tpre_n = sync_tpre_reg[SYNC_DEPTH-1];

  assign edge_det = s_tclk & ~prev_tclk_reg;

  // Banks held in clear never request, so a cleared bank cannot steal a slot.
  assign req = pending_reg & s_tclr_n & {N{run}};

  ttl_rr_arbiter #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  // ---------------------------------------------------------------------------
  // Per-bank next-state logic.
  // A fresh edge wins over a same-cycle grant: the grant consumes the old
  // request and the new edge re-arms pending, so no overflow is flagged.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bank
      assign pending_next[gi] = s_tclr_n[gi] &
                                (edge_det[gi] | (pending_reg[gi] & ~grant[gi]));

      assign ovf_next[gi] = ~ovf_clr &
                            (ovf_reg[gi] |
                             (s_tclr_n[gi] & edge_det[gi] & pending_reg[gi] & ~grant[gi]));

      assign pre_next[gi] = s_tpre_n[gi] | ~s_tclr_n[gi];
    end
  endgenerate

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_valid) begin
      if (grant_idx == PTR_W'(N - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + PTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_tclk_reg <= '0;
      pending_reg   <= '0;
      ovf_reg       <= '0;
      ce_reg        <= '0;
      clr_reg       <= '1;
      pre_reg       <= '1;
      ptr_reg       <= '0;
    end else begin
      prev_tclk_reg <= s_tclk;
      pending_reg   <= pending_next;
      ovf_reg       <= ovf_next;
      ce_reg        <= grant;
      clr_reg       <= s_tclr_n;
      pre_reg       <= pre_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign ce      = ce_reg;
  assign clr_n_o = clr_reg;
  assign pre_n_o = pre_reg;
  assign pending = pending_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_ttl_clk_edge_sched.sv
// tb_ttl_clk_edge_sched
// Directed scenarios followed by a randomized phase. Every cycle the DUT
// outputs are compared with a behavioural model that applies the scheduler's
// rules (sampling delay, rising-edge capture, round-robin service by modular
// search, clear dominance) with plain arithmetic on bit arrays.
module tb_ttl_clk_edge_sched;
  import ttl_sched_pkg::*;

  localparam int N = 4;
  localparam int D = SYNC_DEPTH;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         run;
  logic [N-1:0] tclk;
  logic [N-1:0] tclr_n;
  logic [N-1:0] tpre_n;
  logic         ovf_clr;
  logic [N-1:0] ce;
  logic [N-1:0] clr_n_o;
  logic [N-1:0] pre_n_o;
  logic [N-1:0] pending;
  logic [N-1:0] ovf;

  int n_vec = 0;
  int n_err = 0;

  ttl_clk_edge_sched #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .tclk    (tclk),
    .tclr_n  (tclr_n),
    .tpre_n  (tpre_n),
    .ovf_clr (ovf_clr),
    .ce      (ce),
    .clr_n_o (clr_n_o),
    .pre_n_o (pre_n_o),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [N-1:0] m_sc [D];   // sampled tclk, oldest at D-1
  logic [N-1:0] m_sr [D];
  logic [N-1:0] m_sp [D];
  logic [N-1:0] m_prev, m_pend, m_ovf, m_ce, m_clr, m_pre;
  int           m_ptr;

  function automatic void model_reset();
    for (int j = 0; j < D; j++) begin
      m_sc[j] = '0;
      m_sr[j] = '1;
      m_sp[j] = '1;
    end
    m_prev = '0; m_pend = '0; m_ovf = '0; m_ce = '0;
    m_clr = '1; m_pre = '1; m_ptr = 0;
  endfunction

  // One system clock edge worth of behaviour, using inputs present at the edge.
  function automatic void model_update();
    logic [N-1:0] s_clk, s_clr, s_pre, e, np, no;
    int g;
    s_clk = m_sc[D-1];
    s_clr = m_sr[D-1];
    s_pre = m_sp[D-1];
    e = s_clk & ~m_prev;
    g = -1;
    if (run) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % N] && s_clr[(m_ptr + k) % N])
          g = (m_ptr + k) % N;
      end
    end
    for (int b = 0; b < N; b++) begin
      if (!s_clr[b])      np[b] = 1'b0;
      else if (e[b])      np[b] = 1'b1;
      else if (g == b)    np[b] = 1'b0;
      else                np[b] = m_pend[b];
      if (ovf_clr)        no[b] = 1'b0;
      else if (s_clr[b] && e[b] && m_pend[b] && g != b) no[b] = 1'b1;
      else                no[b] = m_ovf[b];
    end
    m_pend = np;
    m_ovf  = no;
    m_ce   = (g >= 0) ? (N'(1) << g) : '0;
    if (g >= 0) m_ptr = (g + 1) % N;
    m_clr  = s_clr;
    m_pre  = s_pre | ~s_clr;
    m_prev = s_clk;
    for (int j = D - 1; j > 0; j--) begin
      m_sc[j] = m_sc[j-1];
      m_sr[j] = m_sr[j-1];
      m_sp[j] = m_sp[j-1];
    end
    m_sc[0] = tclk;
    m_sr[0] = tclr_n;
    m_sp[0] = tpre_n;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    chk("ce",      ce,      m_ce);
    chk("pending", pending, m_pend);
    chk("ovf",     ovf,     m_ovf);
    chk("clr_n_o", clr_n_o, m_clr);
    chk("pre_n_o", pre_n_o, m_pre);
    chk("ce_onehot0", N'($onehot0(ce)), N'(1));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    model_check();
    $display("t=%0t run=%b tclk=%b clr=%b pre=%b | ce=%b pend=%b ovf=%b clr_o=%b pre_o=%b",
             $time, run, tclk, tclr_n, tpre_n, ce, pending, ovf, clr_n_o, pre_n_o);
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear, releases.
  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ce",      ce,      '0);
    chk("rst_pending", pending, '0);
    chk("rst_ovf",     ovf,     '0);
    chk("rst_clr_n_o", clr_n_o, '1);
    chk("rst_pre_n_o", pre_n_o, '1);
    $display("t=%0t reset applied: ce=%b pend=%b ovf=%b", $time, ce, pending, ovf);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    run = 1'b1; tclk = '0; tclr_n = '1; tpre_n = '1; ovf_clr = 1'b0;
    #1;
    do_reset();
    repeat (3) step();

    // 1: single edge on bank 2
    tclk = 4'b0100;
    repeat (D) step();
    step();
    chk("t1_pending_set", pending, 4'b0100);
    chk("t1_ce_early",    ce,      4'b0000);
    step();
    chk("t1_ce",          ce,      4'b0100);
    chk("t1_pending_clr", pending, 4'b0000);
    step();
    chk("t1_ce_drop",     ce,      4'b0000);

    // 2: contention, all four banks from ptr=0
    tclk = '0;
    repeat (D + 1) step();
    do_reset();
    step();
    tclk = 4'b1111;
    repeat (D + 1) step();
    chk("t2_pending_all", pending, 4'b1111);
    step(); chk("t2_ce0", ce, 4'b0001);
    step(); chk("t2_ce1", ce, 4'b0010);
    step(); chk("t2_ce2", ce, 4'b0100);
    step(); chk("t2_ce3", ce, 4'b1000);
    step();
    chk("t2_ce_idle", ce,  4'b0000);
    chk("t2_no_ovf",  ovf, 4'b0000);

    // 3: overflow with grants frozen
    run = 1'b0; tclk = '0;
    repeat (D + 2) step();
    tclk = 4'b0010;
    repeat (D + 1) step();
    chk("t3_pending_first", pending, 4'b0010);
    tclk = '0;
    repeat (D + 1) step();
    tclk = 4'b0010;
    repeat (D + 1) step();
    chk("t3_ovf_set",  ovf,     4'b0010);
    chk("t3_pending",  pending, 4'b0010);
    run = 1'b1;
    step();
    chk("t3_ce",       ce,      4'b0010);
    step();
    chk("t3_ce_once",  ce,      4'b0000);
    chk("t3_ovf_held", ovf,     4'b0010);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr",  ovf,     4'b0000);

    // 4: clear dominates preset; edges on bank 0 are ignored
    tclk = '0; tclr_n = 4'b1110; tpre_n = 4'b1110;
    repeat (D + 1) step();
    chk("t4_clr_n_o", clr_n_o, 4'b1110);
    chk("t4_pre_n_o", pre_n_o, 4'b1111);
    for (int r = 0; r < 3; r++) begin
      tclk = 4'b0001; repeat (D + 1) step();
      tclk = 4'b0000; repeat (D + 1) step();
    end
    chk("t4_pending", pending, 4'b0000);
    chk("t4_ovf",     ovf,     4'b0000);
    tclr_n = '1; tpre_n = '1;
    repeat (D + 2) step();

    // 5: new edge on bank 3 in the same cycle bank 3 is granted
    run = 1'b0; tclk = 4'b1000;
    repeat (D + 1) step();
    chk("t5_pending", pending, 4'b1000);
    tclk = '0;
    repeat (D + 1) step();
    tclk = 4'b1000;
    repeat (D) step();
    run = 1'b1;
    step();
    chk("t5_ce_first",   ce,      4'b1000);
    chk("t5_pend_kept",  pending, 4'b1000);
    chk("t5_no_ovf",     ovf,     4'b0000);
    step();
    chk("t5_ce_second",  ce,      4'b1000);
    chk("t5_pend_empty", pending, 4'b0000);
    step();
    chk("t5_ce_idle",    ce,      4'b0000);

    // 6: reset while banks 1 and 3 are pending; tclk stays high afterwards
    run = 1'b0; tclk = '0;
    repeat (D + 1) step();
    tclk = 4'b1010;
    repeat (D + 1) step();
    chk("t6_pending", pending, 4'b1010);
    do_reset();
    repeat (6) begin
      step();
      chk("t6_no_strobe", ce, 4'b0000);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) tclk[b] = ~tclk[b];
        tclr_n[b] = ($urandom_range(0, 15) != 0);
        tpre_n[b] = ($urandom_range(0, 7) != 0);
      end
      run     = ($urandom_range(0, 7) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
